omi_mem_responder: RTL and testbench

OMI slave that sits on the memory side of the cache and answers its `o_mem_*` requests from an internal word-addressed SRAM. It accepts single or short-burst reads and writes and returns read data beats on `i_mem_valid`/`i_mem_data`. It is the counterpart of the cache's master port and serves as the memory in cache-level simulation and formal harnesses.

---
 rtl/omi_mem_responder_if.sv | 38 +++
 rtl/omi_mem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_omi_mem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/omi_mem_responder_if.sv
// omi_mem_responder_if
//   Request/response bus between the cache (memory-side master port) and the
//   memory responder. Signal names keep the cache's point of view: o_mem_*
//   are driven by the cache and i_mem_* are driven by the memory.
//
//   o_mem_req   : request, held with all fields until i_mem_rdy
//   o_mem_addr  : byte address (bits [1:0] ignored)
//   o_mem_wen   : 1 = write, 0 = read
//   o_mem_ben   : write byte enables
//   o_mem_data  : write data for the current beat
//   o_mem_len   : beats minus one
//   i_mem_rdy   : accept pulse (per read request / per write beat)
//   i_mem_valid : read beat valid or write-complete ack
//   i_mem_data  : read data, 0 when i_mem_valid is low
interface omi_mem_responder_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                    o_mem_req;
  logic [ADDR_WIDTH-1:0]   o_mem_addr;
  logic                    o_mem_wen;
  logic [DATA_WIDTH/8-1:0] o_mem_ben;
  logic [DATA_WIDTH-1:0]   o_mem_data;
  logic [7:0]              o_mem_len;
  logic                    i_mem_rdy;
  logic                    i_mem_valid;
  logic [DATA_WIDTH-1:0]   i_mem_data;

  modport master (
    output o_mem_req, o_mem_addr, o_mem_wen, o_mem_ben, o_mem_data, o_mem_len,
    input  i_mem_rdy, i_mem_valid, i_mem_data
  );

  modport slave (
    input  o_mem_req, o_mem_addr, o_mem_wen, o_mem_ben, o_mem_data, o_mem_len,
    output i_mem_rdy, i_mem_valid, i_mem_data
  );
endinterface

// File: rtl/omi_mem_responder.sv
// omi_mem_responder
//   Memory-side OMI slave backed by a word-addressed SRAM of
//   2^(ADDR_WIDTH-2) words. Serves single and short-burst reads and writes;
//   burst word indices wrap modulo the SRAM depth. All outputs are registered.
//
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : omi_mem_responder_if.slave (request in, rdy/valid/data out)
//   err_len : sticky, set when a request arrives with len > MAX_LEN
//
// Build option:
//   OMI_MEM_WAIT_EN : when defined, an 8-bit LFSR (seed 8'hA5, taps 8,6,5,4)
//                     inserts a random stall cycle before each rdy pulse and
//                     each read beat.
module omi_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_LEN    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  omi_mem_responder_if.slave   bus,
  output logic                 err_len
);

  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int DEPTH  = 1 << WORD_W;
  localparam int BEN_W  = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_ACK} state_t;

  state_t                state_q, state_d;
  logic [WORD_W-1:0]     base_q, base_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;   // index of the next beat to serve
  logic [2:0]            lat_q, lat_d;
  logic                  rdy_q, rdy_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  stalled_q, stalled_d;

  logic                  wr_en;
  logic                  len_over;
  logic [WORD_W-1:0]     word_idx;
  logic                  stall_bit;
  logic                  stall;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-offset bits of the address carry no information for a word SRAM.
  wire unused_addr_lsb = ^bus.o_mem_addr[1:0];

  assign word_idx = base_q + WORD_W'(beat_q);
  assign len_over = bus.o_mem_len > 8'(MAX_LEN);

`ifdef OMI_MEM_WAIT_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 8'hA5;
    else          lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign stall_bit = lfsr_q[0];
`else
  assign stall_bit = 1'b0;
`endif

  // A stall lasts exactly one cycle: the cycle after a stall always proceeds.
  assign stall = stall_bit & ~stalled_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // through the case statement leaves it unassigned (which would infer a latch).
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    rdy_d     = 1'b0;
    valid_d   = 1'b0;
    data_d    = '0;
    err_d     = err_q;
    stalled_d = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.o_mem_req) begin
          if (stall) begin
            stalled_d = 1'b1;
          end else begin
            base_d  = bus.o_mem_addr[ADDR_WIDTH-1:2];
            len_d   = len_over ? 8'(MAX_LEN) : bus.o_mem_len;
            err_d   = err_q | len_over;
            beat_d  = '0;
            lat_d   = '0;
            rdy_d   = 1'b1;
            state_d = bus.o_mem_wen ? WR_BEAT : RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (lat_q == 3'(RD_LAT - 1)) begin
          if (stall) begin
            stalled_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            data_d  = mem[word_idx];
            beat_d  = beat_q + 8'd1;
            state_d = RD_BEAT;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      RD_BEAT: begin
        if (beat_q > len_q) begin
          state_d = IDLE;
        end else if (stall) begin
          stalled_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          data_d  = mem[word_idx];
          beat_d  = beat_q + 8'd1;
        end
      end

      WR_BEAT: begin
        // The beat is committed at the edge that ends its rdy cycle; rdy then
        // stays low for a cycle so the master can present the next beat.
        if (rdy_q) begin
          wr_en = 1'b1;
          if (beat_q == len_q) begin
            valid_d = 1'b1;
            state_d = WR_ACK;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end else if (bus.o_mem_req) begin
          if (stall) stalled_d = 1'b1;
          else       rdy_d     = 1'b1;
        end
      end

      WR_ACK: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      rdy_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      rdy_q     <= rdy_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      err_q     <= err_d;
      stalled_q <= stalled_d;
    end
  end

  // NOTE: the SRAM array has no reset; its contents survive reset and stay
  // undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BEN_W; b++) begin
        if (bus.o_mem_ben[b]) mem[word_idx][b*8 +: 8] <= bus.o_mem_data[b*8 +: 8];
      end
    end
  end

  assign bus.i_mem_rdy   = rdy_q;
  assign bus.i_mem_valid = valid_q;
  assign bus.i_mem_data  = data_q;
  assign err_len         = err_q;

endmodule

// File: tb/tb_omi_mem_responder.sv
// Self-checking bench for omi_mem_responder (default build, RD_LAT = 1,
// MAX_LEN = 2, 256-word SRAM). Inputs change 1 time unit after a rising edge;
// outputs are sampled on the falling edge.
module tb_omi_mem_responder;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 32;
  localparam int RD_LAT     = 1;
  localparam int MAX_LEN    = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic err_len;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  omi_mem_responder_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  omi_mem_responder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .RD_LAT    (RD_LAT),
    .MAX_LEN   (MAX_LEN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .err_len(err_len)
  );

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [3:0]  ben;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else             passed++;
  endtask

  // Write burst of len+1 beats; checks rdy spacing and the single ack.
  task automatic do_write(input string name, input logic [9:0] addr, input logic [3:0] ben,
                          input logic [7:0] len, input logic [31:0] d0, d1, d2);
    logic [31:0] wd [3];
    int rdy_cnt, rdy_first, rdy_last, ack_cnt, ack_at;
    logic [31:0] ack_data;
    wd = '{d0, d1, d2};
    rdy_cnt = 0; rdy_first = -1; rdy_last = -1; ack_cnt = 0; ack_at = -1; ack_data = '0;
    bus.o_mem_req  = 1'b1;
    bus.o_mem_wen  = 1'b1;
    bus.o_mem_addr = addr;
    bus.o_mem_ben  = ben;
    bus.o_mem_len  = len;
    bus.o_mem_data = wd[0];
    for (int c = 0; c < 20; c++) begin
      bit seen;
      @(negedge clk);
      seen = bus.i_mem_rdy;
      if (seen) begin
        rdy_cnt++;
        if (rdy_first < 0) rdy_first = c;
        rdy_last = c;
      end
      if (bus.i_mem_valid) begin
        ack_cnt++;
        ack_at   = c;
        ack_data = bus.i_mem_data;
      end
      @(posedge clk); #1;
      if (seen) begin
        if (rdy_cnt >= int'(len) + 1 || rdy_cnt >= 3) bus.o_mem_req = 1'b0;
        else                                         bus.o_mem_data = wd[rdy_cnt];
      end
    end
    check({name, "_rdy_first"}, rdy_first, 1);
    check({name, "_rdy_count"}, rdy_cnt, int'(len) + 1);
    check({name, "_rdy_last"},  rdy_last, 1 + 2 * int'(len));
    check({name, "_ack_count"}, ack_cnt, 1);
    check({name, "_ack_at"},    ack_at, rdy_last + 1);
    check({name, "_ack_data"},  ack_data, 32'h0);
  endtask

  // Read burst; checks rdy timing, beat count, first-beat latency, gaps, data.
  task automatic do_read(input string name, input logic [9:0] addr, input logic [7:0] len,
                         input int n_exp, input logic [31:0] e0, e1, e2);
    logic [31:0] exp_d [3];
    logic [31:0] got [3];
    int rdy_cnt, rdy_first, beats, first, last;
    bit consec;
    exp_d = '{e0, e1, e2};
    got   = '{32'h0, 32'h0, 32'h0};
    rdy_cnt = 0; rdy_first = -1; beats = 0; first = -1; last = -1; consec = 1'b1;
    bus.o_mem_req  = 1'b1;
    bus.o_mem_wen  = 1'b0;
    bus.o_mem_addr = addr;
    bus.o_mem_ben  = 4'h0;
    bus.o_mem_len  = len;
    bus.o_mem_data = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.i_mem_rdy) begin
        rdy_cnt++;
        if (rdy_first < 0) rdy_first = c;
      end
      if (bus.i_mem_valid) begin
        if (beats < 3) got[beats] = bus.i_mem_data;
        if (first < 0) first = c;
        else if (c != last + 1) consec = 1'b0;
        last = c;
        beats++;
      end
      @(posedge clk); #1;
      if (rdy_first >= 0) bus.o_mem_req = 1'b0;
    end
    check({name, "_rdy_at"},      rdy_first, 1);
    check({name, "_rdy_count"},   rdy_cnt, 1);
    check({name, "_beats"},       beats, n_exp);
    check({name, "_first_beat"},  first, 1 + RD_LAT);
    check({name, "_consecutive"}, 32'(consec), 32'h1);
    for (int k = 0; k < n_exp && k < 3; k++)
      check($sformatf("%s_data%0d", name, k), got[k], exp_d[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rdy_mask, valid_mask;
    logic [31:0] b2b_data [3];
    int nb;

    vecs[0] = '{1'b1, 10'h010, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 10'h010, 4'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 10'h020, 4'hF, 32'hFFFFFFFF};
    vecs[3] = '{1'b1, 10'h020, 4'b0101, 32'h12345678};
    vecs[4] = '{1'b0, 10'h020, 4'h0, 32'hFF34FF78};
    vecs[5] = '{1'b1, 10'h022, 4'b1000, 32'h11000000};  // addr[1:0] ignored
    vecs[6] = '{1'b0, 10'h023, 4'h0, 32'h1134FF78};
    vecs[7] = '{1'b1, 10'h3FC, 4'hF, 32'h0BADF00D};

    bus.o_mem_req  = 1'b0;
    bus.o_mem_wen  = 1'b0;
    bus.o_mem_addr = '0;
    bus.o_mem_ben  = '0;
    bus.o_mem_data = '0;
    bus.o_mem_len  = '0;
    reset_n = 1'b0;
    #1;
    check("reset_rdy",   32'(bus.i_mem_rdy),   32'h0);
    check("reset_valid", 32'(bus.i_mem_valid), 32'h0);
    check("reset_data",  bus.i_mem_data,       32'h0);
    check("reset_err",   32'(err_len),         32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat table.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr)
        do_write($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].ben, 8'd0, vecs[i].data, 32'h0, 32'h0);
      else
        do_read($sformatf("vec%0d_rd", i), vecs[i].addr, 8'd0, 1, vecs[i].data, 32'h0, 32'h0);
    end
    do_read("top_word_rd", 10'h3FC, 8'd0, 1, 32'h0BADF00D, 32'h0, 32'h0);
    check("err_clear_after_legal", 32'(err_len), 32'h0);

    // Burst across the top of the SRAM.
    do_write("wrap_wr", 10'h3F8, 4'hF, 8'd2, 32'd1, 32'd2, 32'd3);
    do_read ("wrap_rd", 10'h3F8, 8'd2, 3, 32'd1, 32'd2, 32'd3);
    do_read ("wrap_word0", 10'h000, 8'd0, 1, 32'd3, 32'h0, 32'h0);

    // Oversized len is clamped to MAX_LEN and flags err_len.
    do_read("len_err_rd", 10'h3F8, 8'd5, MAX_LEN + 1, 32'd1, 32'd2, 32'd3);
    check("err_len_set", 32'(err_len), 32'h1);
    do_write("after_err_wr", 10'h040, 4'hF, 8'd0, 32'hCAFEF00D, 32'h0, 32'h0);
    check("err_len_sticky", 32'(err_len), 32'h1);

    // Reset asserted during beat 1 of a len-2 read.
    bus.o_mem_req  = 1'b1;
    bus.o_mem_wen  = 1'b0;
    bus.o_mem_addr = 10'h3F8;
    bus.o_mem_len  = 8'd2;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) begin
        check("rst_mid_beat1_valid", 32'(bus.i_mem_valid), 32'h1);
        check("rst_mid_beat1_data",  bus.i_mem_data,       32'd2);
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.i_mem_valid), 32'h0);
        check("rst_mid_data",  bus.i_mem_data,       32'h0);
        check("rst_mid_err",   32'(err_len),         32'h0);
      end else begin
        @(posedge clk); #1;
        if (c == 1) bus.o_mem_req = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_read("post_rst_rd",    10'h010, 8'd0, 1, 32'hDEADBEEF, 32'h0, 32'h0);
    do_read("post_rst_word0", 10'h000, 8'd0, 1, 32'd3, 32'h0, 32'h0);

    // Back-to-back: second read (len 0) held during the last beat of a len-1 read.
    rdy_mask = '0; valid_mask = '0; nb = 0;
    b2b_data = '{32'h0, 32'h0, 32'h0};
    bus.o_mem_req  = 1'b1;
    bus.o_mem_wen  = 1'b0;
    bus.o_mem_addr = 10'h3F8;
    bus.o_mem_len  = 8'd1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rdy_mask[c]   = bus.i_mem_rdy;
      valid_mask[c] = bus.i_mem_valid;
      if (bus.i_mem_valid) begin
        if (nb < 3) b2b_data[nb] = bus.i_mem_data;
        nb++;
      end
      @(posedge clk); #1;
      if (c == 1 || c == 5) bus.o_mem_req = 1'b0;
      if (c == 2) begin
        bus.o_mem_req  = 1'b1;
        bus.o_mem_addr = 10'h010;
        bus.o_mem_len  = 8'd0;
      end
    end
    check("b2b_rdy_cycles",   32'(rdy_mask),   32'h0022);
    check("b2b_valid_cycles", 32'(valid_mask), 32'h004C);
    check("b2b_beat_count",   nb,              3);
    check("b2b_data0",        b2b_data[0],     32'd1);
    check("b2b_data1",        b2b_data[1],     32'd2);
    check("b2b_data2",        b2b_data[2],     32'hDEADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
